// File: rtl/bist_ctrl_9x2.sv
// Self-test wrapper: LFSR stimulus generator plus MISR response compactor for 9-in/2-out cores.
// Latency: one pattern per cycle; done rises NUM_PATS edges after the start edge.
// Backpressure: none; start is honoured only in IDLE or DONE and ignored while running.
module bist_ctrl_9x2 #(
  parameter int unsigned NUM_PATS  = 511,
  parameter logic [8:0]  LFSR_SEED = 9'h001,
  parameter logic [15:0] MISR_SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [8:0]  pat_out,
  output logic        pat_valid,
  input  logic [1:0]  rsp_in,
  output logic [15:0] signature,
  output logic [8:0]  pat_count,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // pat_count value seen before the final compaction edge
  localparam logic [8:0] LAST_CNT = 9'(NUM_PATS - 1);

  state_e      state_q, state_d;
  logic [8:0]  pat_q, pat_d;
  logic [15:0] sig_q, sig_d;
  logic [8:0]  cnt_q, cnt_d;

  logic [8:0]  lfsr_nxt;
  logic [15:0] misr_nxt;
  logic        last_pat;

  // LFSR x^9+x^5+1 and MISR x^16+x^12+x^5+1 one-step next values
  always_comb begin
    lfsr_nxt = {pat_q[7:0], pat_q[8] ^ pat_q[4]};
    misr_nxt = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)) ^ {14'b0, rsp_in};
    last_pat = (cnt_q == LAST_CNT);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only acts outside RUN, RUN ends on the last compaction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_pat) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: pattern, signature, count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 9'h000;
      sig_q <= 16'h0000;
      cnt_q <= 9'h000;
    end else begin
      pat_q <= pat_d;
      sig_q <= sig_d;
      cnt_q <= cnt_d;
    end
  end

  // Datapath next values; rsp_in is only consumed in RUN so X elsewhere cannot leak in
  always_comb begin
    pat_d = pat_q;
    sig_d = sig_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d = LFSR_SEED;
          sig_d = MISR_SEED;
          cnt_d = 9'h000;
        end
      end
      S_RUN: begin
        sig_d = misr_nxt;
        cnt_d = cnt_q + 9'd1;
        // on the last edge the final live pattern is held for DONE
        if (!last_pat) pat_d = lfsr_nxt;
      end
      default: begin
        pat_d = pat_q;
      end
    endcase
  end

  // Output decode from state and datapath registers
  always_comb begin
    pat_out   = pat_q;
    signature = sig_q;
    pat_count = cnt_q;
    pat_valid = (state_q == S_RUN);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_bist_ctrl_9x2.sv
// Directed bench for bist_ctrl_9x2: full-length sessions, short sessions, restart and mid-run reset.
// Three instances cover NUM_PATS = 511, 2 and 1.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bist_ctrl_9x2;

  logic clk;
  logic rst_n;

  // main instance, NUM_PATS = 511
  logic        start;
  logic [8:0]  pat_out;
  logic        pat_valid;
  logic [1:0]  rsp_in;
  logic [15:0] signature;
  logic [8:0]  pat_count;
  logic        busy, done;
  logic        rsp_mode;

  // NUM_PATS = 2 instance
  logic        start2;
  logic [8:0]  pat_out2;
  logic        pat_valid2;
  logic [15:0] signature2;
  logic [8:0]  pat_count2;
  logic        busy2, done2;

  // NUM_PATS = 1 instance
  logic        start1;
  logic [8:0]  pat_out1;
  logic        pat_valid1;
  logic [15:0] signature1;
  logic [8:0]  pat_count1;
  logic        busy1, done1;

  int n_chk;
  int n_pass;

  logic [15:0] model_sig;
  logic [511:0] seen;
  logic [8:0]  first6 [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bist_ctrl_9x2 #(.NUM_PATS(511), .LFSR_SEED(9'h001), .MISR_SEED(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_out(pat_out), .pat_valid(pat_valid),
    .rsp_in(rsp_in), .signature(signature), .pat_count(pat_count), .busy(busy), .done(done)
  );

  bist_ctrl_9x2 #(.NUM_PATS(2), .LFSR_SEED(9'h001), .MISR_SEED(16'h0000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pat_out(pat_out2), .pat_valid(pat_valid2),
    .rsp_in(2'b01), .signature(signature2), .pat_count(pat_count2), .busy(busy2), .done(done2)
  );

  bist_ctrl_9x2 #(.NUM_PATS(1), .LFSR_SEED(9'h001), .MISR_SEED(16'h0000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pat_out(pat_out1), .pat_valid(pat_valid1),
    .rsp_in(2'b10), .signature(signature1), .pat_count(pat_count1), .busy(busy1), .done(done1)
  );

  // Reference core: an arbitrary 9-in/2-out combinational function
  function automatic logic [1:0] core_fn(input logic [8:0] p);
    return {(p[8] & p[1]) | (p[3] ^ p[6]), ^(p & 9'h0B5)};
  endfunction

  function automatic logic [8:0] lfsr_step(input logic [8:0] q);
    return {q[7:0], q[8] ^ q[4]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [1:0] r);
    return ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {14'b0, r};
  endfunction

  // Core model drives X whenever no live pattern is presented
  always_comb begin
    if (!rsp_mode)       rsp_in = 2'b00;
    else if (pat_valid)  rsp_in = core_fn(pat_out);
    else                 rsp_in = 2'bxx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts a session from a negedge and checks n_cyc RUN cycles against the LFSR model.
  // pulse_at >= 0 raises start for one cycle mid-run; it must have no effect.
  task automatic run_main(input int n_cyc, input int pulse_at);
    logic [8:0] exp_p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_p = 9'h001;
    seen  = '0;
    chk("done_drops_on_start", {31'b0, done}, 32'd0);
    for (int i = 0; i < n_cyc; i++) begin
      start = 1'b0;
      chk("busy_run",      {31'b0, busy},      32'd1);
      chk("pat_valid_run", {31'b0, pat_valid}, 32'd1);
      chk("pat_seq",       {23'b0, pat_out},   {23'b0, exp_p});
      chk("pat_count_run", {23'b0, pat_count}, i);
      chk("pat_distinct",  {31'b0, seen[pat_out]}, 32'd0);
      if (pat_out == 9'h000) chk("pat_nonzero", {23'b0, pat_out}, 32'd1);
      if (i < 6) chk("pat_first6", {23'b0, pat_out}, {23'b0, first6[i]});
      seen[pat_out] = 1'b1;
      exp_p = lfsr_step(exp_p);
      if (i == pulse_at) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pat_out"},   {23'b0, pat_out},   32'd0);
    chk({tag, "_pat_valid"}, {31'b0, pat_valid}, 32'd0);
    chk({tag, "_signature"}, {16'b0, signature}, 32'd0);
    chk({tag, "_pat_count"}, {23'b0, pat_count}, 32'd0);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_done"},      {31'b0, done},      32'd0);
  endtask

  task automatic chk_main_done(input string tag, input logic [15:0] exp_sig);
    chk({tag, "_done"},      {31'b0, done},      32'd1);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_pat_valid"}, {31'b0, pat_valid}, 32'd0);
    chk({tag, "_pat_count"}, {23'b0, pat_count}, 32'd511);
    chk({tag, "_signature"}, {16'b0, signature}, {16'b0, exp_sig});
  endtask

  initial begin
    logic [8:0] p;
    n_chk = 0;
    n_pass = 0;
    first6[0] = 9'h001; first6[1] = 9'h002; first6[2] = 9'h004;
    first6[3] = 9'h008; first6[4] = 9'h010; first6[5] = 9'h021;

    // expected signature of a full session against the reference core
    p = 9'h001;
    model_sig = 16'h0000;
    for (int i = 0; i < 511; i++) begin
      model_sig = misr_step(model_sig, core_fn(p));
      p = lfsr_step(p);
    end

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; start1 = 1'b0; rsp_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays", {31'b0, busy}, 32'd0);

    // NUM_PATS = 2, rsp_in = 01
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("np2_busy0",  {31'b0, busy2},      32'd1);
    chk("np2_valid0", {31'b0, pat_valid2}, 32'd1);
    chk("np2_pat0",   {23'b0, pat_out2},   32'h001);
    chk("np2_sig0",   {16'b0, signature2}, 32'h0000);
    @(negedge clk);
    chk("np2_busy1",  {31'b0, busy2},      32'd1);
    chk("np2_sig1",   {16'b0, signature2}, 32'h0001);
    chk("np2_cnt1",   {23'b0, pat_count2}, 32'd1);
    @(negedge clk);
    chk("np2_done",   {31'b0, done2},      32'd1);
    chk("np2_busy2",  {31'b0, busy2},      32'd0);
    chk("np2_sig2",   {16'b0, signature2}, 32'h0003);
    chk("np2_cnt2",   {23'b0, pat_count2}, 32'd2);
    @(negedge clk);
    chk("np2_hold",   {16'b0, signature2}, 32'h0003);

    // NUM_PATS = 1, rsp_in = 10
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("np1_busy",  {31'b0, busy1},      32'd1);
    chk("np1_valid", {31'b0, pat_valid1}, 32'd1);
    chk("np1_pat",   {23'b0, pat_out1},   32'h001);
    @(negedge clk);
    chk("np1_done",  {31'b0, done1},      32'd1);
    chk("np1_busy1", {31'b0, busy1},      32'd0);
    chk("np1_sig",   {16'b0, signature1}, 32'h0002);
    chk("np1_cnt",   {23'b0, pat_count1}, 32'd1);

    // full session, response tied to zero
    run_main(511, -1);
    chk_main_done("s1", 16'h0000);
    @(negedge clk);
    chk("s1_hold_done", {31'b0, done}, 32'd1);
    chk("s1_hold_cnt",  {23'b0, pat_count}, 32'd511);

    // restart from DONE with the reference core; start pulse mid-run is ignored
    rsp_mode = 1'b1;
    run_main(511, 50);
    chk_main_done("s2", model_sig);

    // abort at pattern 100 with an asynchronous reset between clock edges
    run_main(100, -1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    chk_reset_vals("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_partial_done", {31'b0, done}, 32'd0);

    // session after the abort matches an uninterrupted one
    run_main(511, -1);
    chk_main_done("s4", model_sig);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
